xor_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one 5-bit XOR datapath among four requesters in the ALU project. Each requester presents two 5-bit operands with a request line. The block grants one requester at a time and latches its operands. It drives the shared XOR datapath, registers the result, and returns it through a valid/ready handshake tagged with the requester ID.

---
 rtl/xor_share_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: grants one of NREQ requesters at a time, runs its operands
// through a shared registered XOR datapath, and returns the result over a
// valid/ready handshake tagged with the requester index.
// Build option: define XOR_SHARE_FIXED_PRIO_EN for fixed priority (req[0]
// highest). The default build uses round-robin.
module xor_share_arbiter #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      res,
  output logic [1:0]            res_id,
  output logic                  res_valid,
  input  logic                  res_ready
);
  localparam int IDW    = 2;
  // One register stage sits in the XOR datapath, so BUSY spans two cycles.
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  logic [NREQ-1:0][WIDTH-1:0] a_v, b_v;
  assign a_v = op_a;
  assign b_v = op_b;

  state_t           state_q, state_d;
  logic             grant;
  logic             win_vld;
  logic [IDW-1:0]   win_id, idx, start;
  op_t              lat;
  logic [WIDTH-1:0] x_q;
  logic [STAGES:0]  vld_pipe;
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] res_q;
  logic [IDW-1:0]   res_id_q;
  logic             res_valid_q;

`ifdef XOR_SHARE_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] ptr;
  // Round-robin pointer: the search after a grant starts just past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= '0;
    else if (grant) ptr <= win_id + 1'b1;
  end
  assign start = ptr;
`endif

  // Winner search from start, wrapping through the 2-bit index.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start + IDW'(k);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; a grant is only issued from IDLE.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: if (win_vld) begin
        grant   = 1'b1;
        state_d = BUSY;
      end
      BUSY:    if (vld_pipe[STAGES]) state_d = HOLD;
      HOLD:    if (res_ready)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, shared XOR stage and result/handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      lat         <= '0;
      x_q         <= '0;
      vld_pipe    <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      gnt_q    <= grant ? (NREQ'(1) << win_id) : '0;
      vld_pipe <= {vld_pipe[STAGES-1:0], grant};
      if (grant)
        lat <= '{id: win_id, a: a_v[win_id], b: b_v[win_id]};
      if (vld_pipe[0])
        x_q <= lat.a ^ lat.b;
      if (state_q == BUSY && vld_pipe[STAGES]) begin
        res_q       <= x_q;
        res_id_q    <= lat.id;
        res_valid_q <= 1'b1;
      end else if (state_q == HOLD && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign gnt       = gnt_q;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
endmodule
